icap_config_reader: RTL and testbench
=====================================

Name: icap_config_reader

Overview:
- Reads one 16-bit Spartan-3A configuration register through the ICAP port. This is the read counterpart of the MultiBoot trigger; typical targets are GENERAL1/GENERAL2, to confirm the programmed next-image address.
- On each request it performs SYNC, a Type 1 read header, turnaround, a 2-byte readback, turnaround back, then DESYNC.
- ICAP_SPARTAN3A is instantiated at the top level. This block drives and samples the primitive's ports and owns the bit reversal.

Parameters:
CLK_DIV, 3, clk cycles per ICAP clock period; legal values are 3 to 15.
BUSY_TIMEOUT, 32, ICAP clock periods allowed in the read phase waiting for BUSY low.

Ports:
clk  in  1  free-running system clock
rst  in  1  synchronous, active-high reset
req  in  1  start a read; sampled only while ready=1
reg_addr  in  6  configuration register address (GENERAL1=0x13, GENERAL2=0x14)
ready  out  1  high when idle and able to accept req
rd_data  out  16  register value, MSB first on ICAP; held until the next accepted req
rd_valid  out  1  one-cycle pulse at completion
rd_error  out  1  valid with rd_valid; 1 = BUSY timeout, in which case rd_data=0x0000
icap_clk  out  1  to ICAP CLK
icap_ce  out  1  to ICAP CE, active low
icap_write  out  1  to ICAP WRITE, low = write, high = read
icap_i  out  8  to ICAP I, ICAP bit order (bit0 = MSB)
icap_o  in  8  from ICAP O, ICAP bit order
icap_busy  in  1  from ICAP BUSY

Behaviour:
Reset values:
- ready=1, rd_valid=0, rd_error=0, rd_data=0x0000.
- icap_clk=0, icap_ce=1, icap_write=1, icap_i=0x00.
- FSM in IDLE; tick counter=0.

ICAP clock generation:
- A tick counter runs 0..CLK_DIV-1, only outside IDLE.
- icap_clk=1 exactly when count==1.
- The "advance" strobe fires at count==CLK_DIV-1.
- icap_i, icap_ce and icap_write change only on advance, so they are stable around each ICAP rising edge.
- icap_o and icap_busy are sampled on advance.

Request acceptance:
- req while ready=1 latches reg_addr and drops ready on the next cycle.
- req while ready=0 is ignored; there is no queueing.

FSM (each step below is one ICAP clock period):
- WR_SYNC: CE=0, WRITE=0. Bytes FF FF AA 99 20 00 H_hi H_lo 20 00 20 00, where H = 0x2800 | (reg_addr<<5) | 0x01 (Type 1, read, word count 1).
- TURN_RD: period 1 has CE=1, WRITE=0; period 2 has CE=1, WRITE=1.
- READ: CE=0, WRITE=1.
  - Each sample with busy=0 captures icap_o, bit-reversed. The first capture goes to rd_data[15:8], the second to rd_data[7:0].
  - The state exits after the second capture.
  - Samples with busy=1 are discarded and increment the timeout count.
  - When the count reaches BUSY_TIMEOUT: set the error flag, force data to 0, and proceed.
- TURN_WR: period 1 has CE=1, WRITE=1; period 2 has CE=1, WRITE=0.
- WR_DESYNC: CE=0, WRITE=0. Bytes 30 A1 00 0D 20 00 20 00.
- DONE: CE=1, WRITE=1, icap_i=0. On the next clk, rd_valid=1, rd_error is set, ready=1, and the FSM returns to IDLE.

Latency:
- With busy always 0: 26 ICAP periods.
- req accepted at cycle 0 gives rd_valid at cycle 26*CLK_DIV+1 (79 for the default).

Boundary and exception cases:
- rd_data updates only in the rd_valid cycle.
- BUSY toggling during READ: only busy=0 samples count as data.
- BUSY is ignored in all write states.
- rst mid-operation: everything returns to reset values immediately and no DESYNC is issued. The next request re-SYNCs, which is harmless on an already-synced port.
- req in the same cycle as rst is dropped.

Decomposition:
- Package icap_s3a_pkg holds:
  - constants SYNC=0xAA99, NOOP=0x2000, CMD_WR=0x30A1, DESYNC=0x000D;
  - register addresses GENERAL1/2 and STAT;
  - the read-header build function;
  - the FSM state enum.
- Sub-module icap_clk_gen: the tick counter; outputs icap_clk and advance; input run.

Test Plan:
- GENERAL2 read (addr 0x14), ICAP model returns bytes 0x00,0x02 with busy=0:
  - icap_i stream is FF FF AA 99 20 00 2A 81 20 00 20 00 | read | 30 A1 00 0D 20 00 20 00;
  - rd_data=0x0002, rd_error=0, rd_valid at cycle 79.
- GENERAL1 read (addr 0x13), model busy=1 for 5 read samples, then 0x12,0x34:
  - header bytes 2A 61;
  - rd_data=0x1234, rd_valid delayed by 5*3 cycles.
- busy held at 1: after 32 read samples, rd_error=1, rd_data=0x0000, DESYNC still issued, ready returns to 1.
- req pulsed repeatedly during a transfer: a single transaction occurs; a second req after ready=1 starts a fresh SYNC.
- rst asserted mid-READ: the next cycle shows icap_ce=1, icap_write=1, icap_clk=0, ready=1, no rd_valid; a subsequent read succeeds.
- CLK_DIV=5:
  - icap_clk high 1 of every 5 cycles;
  - icap_i, icap_ce and icap_write never change while icap_clk=1 or in the cycle before it;
  - rd_valid at cycle 131.

Source files
------------

// File: rtl/icap_s3a_pkg.sv
// Spartan-3A ICAP configuration words, register addresses and the reader FSM state type.
package icap_s3a_pkg;

    localparam logic [15:0] SYNC   = 16'hAA99;
    localparam logic [15:0] NOOP   = 16'h2000;
    localparam logic [15:0] CMD_WR = 16'h30A1;
    localparam logic [15:0] DESYNC = 16'h000D;

    localparam logic [5:0] REG_STAT     = 6'h08;
    localparam logic [5:0] REG_GENERAL1 = 6'h13;
    localparam logic [5:0] REG_GENERAL2 = 6'h14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SYNC,
        ST_TURN_RD,
        ST_READ,
        ST_TURN_WR,
        ST_WR_DESYNC,
        ST_DONE
    } state_e;

    // Type 1 packet header: read opcode, register address, word count of one.
    function automatic logic [15:0] read_hdr(input logic [5:0] addr);
        return 16'h2800 | {5'd0, addr, 5'd0} | 16'h0001;
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = b[7-k];
        return r;
    endfunction

endpackage

// File: rtl/icap_clk_gen.sv
// Divided ICAP clock: high on count 1, advance strobe on the last count of each period.
module icap_clk_gen #(
    parameter int CLK_DIV = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic icap_clk_o,
    output logic advance_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q;

    always_comb begin
        cnt_d = '0;
        if (run_i && cnt_q != CW'(CLK_DIV - 1)) cnt_d = cnt_q + 1'b1;
    end

    // icap_clk is registered from the next count so it is glitch-free yet equals (count == 1).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= (cnt_d == CW'(1));
        end
    end

    assign icap_clk_o = clk_q;
    assign advance_o  = run_i && (cnt_q == CW'(CLK_DIV - 1));

endmodule

// File: rtl/icap_config_reader.sv
// Reads one 16-bit configuration register over ICAP: SYNC, read header, turnaround, readback, DESYNC.
module icap_config_reader #(
    parameter int CLK_DIV      = 3,
    parameter int BUSY_TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [5:0]  reg_addr,
    output logic        ready,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        rd_error,
    output logic        icap_clk,
    output logic        icap_ce,
    output logic        icap_write,
    output logic [7:0]  icap_i,
    input  logic [7:0]  icap_o,
    input  logic        icap_busy
);

    import icap_s3a_pkg::*;

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    state_e        state_q;
    logic [5:0]    addr_q;
    logic [3:0]    idx_q;
    logic [TW-1:0] to_q;
    logic          nb_q, fail_q;
    logic [15:0]   buf_q, rd_data_q;
    logic          ready_q, valid_q, error_q;
    logic          ce_q, write_q;
    logic [7:0]    i_q;
    logic          run, adv;
    logic [15:0]   hdr;

    assign hdr = read_hdr(addr_q);
    assign run = (state_q != ST_IDLE) && (state_q != ST_DONE);

    icap_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .run_i      (run),
        .icap_clk_o (icap_clk),
        .advance_o  (adv)
    );

    // Logical (MSB-first) byte of the write sequence at position idx.
    function automatic logic [7:0] seq_byte(input state_e st, input logic [3:0] idx,
                                            input logic [15:0] h);
        logic [15:0] w;
        w = NOOP;
        if (st == ST_WR_SYNC) begin
            case (idx[3:1])
                3'd0:    w = 16'hFFFF;
                3'd1:    w = SYNC;
                3'd3:    w = h;
                default: w = NOOP;
            endcase
        end else begin
            case (idx[3:1])
                3'd0:    w = CMD_WR;
                3'd1:    w = DESYNC;
                default: w = NOOP;
            endcase
        end
        return idx[0] ? w[7:0] : w[15:8];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            idx_q     <= '0;
            to_q      <= '0;
            nb_q      <= 1'b0;
            fail_q    <= 1'b0;
            buf_q     <= '0;
            rd_data_q <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            ce_q      <= 1'b1;
            write_q   <= 1'b1;
            i_q       <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (req) begin
                    addr_q  <= reg_addr;
                    ready_q <= 1'b0;
                    state_q <= ST_WR_SYNC;
                    idx_q   <= '0;
                    to_q    <= '0;
                    nb_q    <= 1'b0;
                    fail_q  <= 1'b0;
                    buf_q   <= '0;
                    ce_q    <= 1'b0;
                    write_q <= 1'b0;
                    i_q     <= bitrev8(8'hFF);
                end
                ST_WR_SYNC: if (adv) begin
                    if (idx_q == 4'd11) begin
                        state_q <= ST_TURN_RD;
                        idx_q   <= '0;
                        ce_q    <= 1'b1;
                        i_q     <= '0;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                        i_q   <= bitrev8(seq_byte(ST_WR_SYNC, idx_q + 4'd1, hdr));
                    end
                end
                ST_TURN_RD: if (adv) begin
                    if (idx_q == 4'd0) begin
                        idx_q   <= 4'd1;
                        write_q <= 1'b1;
                    end else begin
                        state_q <= ST_READ;
                        ce_q    <= 1'b0;
                    end
                end
                // Busy samples only burn timeout budget; a timeout zeroes any partial data.
                ST_READ: if (adv) begin
                    if (icap_busy) begin
                        if (to_q == TW'(BUSY_TIMEOUT - 1)) begin
                            fail_q  <= 1'b1;
                            buf_q   <= '0;
                            state_q <= ST_TURN_WR;
                            idx_q   <= '0;
                            ce_q    <= 1'b1;
                        end else begin
                            to_q <= to_q + 1'b1;
                        end
                    end else if (nb_q) begin
                        buf_q[7:0] <= bitrev8(icap_o);
                        state_q    <= ST_TURN_WR;
                        idx_q      <= '0;
                        ce_q       <= 1'b1;
                    end else begin
                        buf_q[15:8] <= bitrev8(icap_o);
                        nb_q        <= 1'b1;
                    end
                end
                ST_TURN_WR: if (adv) begin
                    if (idx_q == 4'd0) begin
                        idx_q   <= 4'd1;
                        write_q <= 1'b0;
                    end else begin
                        state_q <= ST_WR_DESYNC;
                        idx_q   <= '0;
                        ce_q    <= 1'b0;
                        i_q     <= bitrev8(seq_byte(ST_WR_DESYNC, 4'd0, hdr));
                    end
                end
                ST_WR_DESYNC: if (adv) begin
                    if (idx_q == 4'd7) begin
                        state_q <= ST_DONE;
                        ce_q    <= 1'b1;
                        write_q <= 1'b1;
                        i_q     <= '0;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                        i_q   <= bitrev8(seq_byte(ST_WR_DESYNC, idx_q + 4'd1, hdr));
                    end
                end
                ST_DONE: begin
                    state_q   <= ST_IDLE;
                    valid_q   <= 1'b1;
                    error_q   <= fail_q;
                    rd_data_q <= buf_q;
                    ready_q   <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready      = ready_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = valid_q;
    assign rd_error   = error_q;
    assign icap_ce    = ce_q;
    assign icap_write = write_q;
    assign icap_i     = i_q;

endmodule

// File: tb/tb_icap_config_reader.sv
// Bench for icap_config_reader: ICAP behavioural model, byte/result scoreboards, table-driven reads.
module tb_icap_config_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, req = 1'b0, sel = 1'b0, chk_stab = 1'b0;
    logic [5:0] reg_addr = 6'h00;
    logic [7:0] icap_o = 8'h00;
    logic       icap_busy = 1'b0;
    logic       req3, req5;
    assign req3 = req & ~sel;
    assign req5 = req & sel;

    logic        ready3, valid3, err3, clk3, ce3, wr3;
    logic        ready5, valid5, err5, clk5, ce5, wr5;
    logic [15:0] data3, data5;
    logic [7:0]  i3, i5;

    icap_config_reader #(.CLK_DIV(3), .BUSY_TIMEOUT(32)) dut (
        .clk(clk), .rst(rst), .req(req3), .reg_addr(reg_addr),
        .ready(ready3), .rd_data(data3), .rd_valid(valid3), .rd_error(err3),
        .icap_clk(clk3), .icap_ce(ce3), .icap_write(wr3), .icap_i(i3),
        .icap_o(icap_o), .icap_busy(icap_busy));

    icap_config_reader #(.CLK_DIV(5), .BUSY_TIMEOUT(32)) dut5 (
        .clk(clk), .rst(rst), .req(req5), .reg_addr(reg_addr),
        .ready(ready5), .rd_data(data5), .rd_valid(valid5), .rd_error(err5),
        .icap_clk(clk5), .icap_ce(ce5), .icap_write(wr5), .icap_i(i5),
        .icap_o(icap_o), .icap_busy(icap_busy));

    logic        m_ready, m_valid, m_err, m_clk, m_ce, m_wr;
    logic [15:0] m_data;
    logic [7:0]  m_i;
    assign m_ready = sel ? ready5 : ready3;
    assign m_valid = sel ? valid5 : valid3;
    assign m_err   = sel ? err5   : err3;
    assign m_clk   = sel ? clk5   : clk3;
    assign m_ce    = sel ? ce5    : ce3;
    assign m_wr    = sel ? wr5    : wr3;
    assign m_data  = sel ? data5  : data3;
    assign m_i     = sel ? i5     : i3;

    typedef struct { logic [15:0] data; logic err; int lat; } res_t;
    typedef struct {
        logic [5:0] addr; logic [15:0] hdr; int pre; int mid;
        logic [7:0] hi; logic [7:0] lo; logic [15:0] data; logic err; int lat;
    } vec_t;

    res_t       res_q[$];
    logic [7:0] byte_q[$];
    res_t       mon_r;
    vec_t       vt[8];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, t0 = 0;
    int m_pre = 0, m_mid = 0;
    logic [7:0] m_hi = 8'h00, m_lo = 8'h00;
    int rdk = 0, stab_viol = 0, gap_viol = 0, hold_viol = 0, last_rise = 0;
    logic have_rise = 1'b0, prev_clk = 1'b0, prev_ce = 1'b1, prev_wr = 1'b1, rst_s = 1'b1;
    logic [7:0]  prev_i = 8'h00;
    logic [15:0] ld3 = 16'h0000, ld5 = 16'h0000;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = b[7-k];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    // ICAP model, write-byte scoreboard, result scoreboard and timing observers.
    always @(negedge clk) begin
        logic rise;
        rise = m_clk && !prev_clk;
        if (m_ready) begin
            rdk       = 0;
            have_rise = 1'b0;
        end
        if (rise && !m_ce && m_wr) begin
            if (rdk < m_pre || (rdk > m_pre && rdk <= m_pre + m_mid)) begin
                icap_busy = 1'b1; icap_o = 8'hC3;
            end else if (rdk == m_pre) begin
                icap_busy = 1'b0; icap_o = rev8(m_hi);
            end else if (rdk == m_pre + m_mid + 1) begin
                icap_busy = 1'b0; icap_o = rev8(m_lo);
            end else begin
                icap_busy = 1'b0; icap_o = 8'h00;
            end
            rdk++;
        end
        if (rise && !m_ce && !m_wr) begin
            icap_busy = 1'b1;
            icap_o    = 8'h5A;
            if (byte_q.size() == 0) check("icap_i_extra_byte", byte_q.size(), 1);
            else check("icap_i_byte", rev8(m_i), byte_q.pop_front());
        end
        if (m_valid) begin
            if (res_q.size() == 0) check("rd_valid_unexpected", res_q.size(), 1);
            else begin
                mon_r = res_q.pop_front();
                check("rd_data", m_data, mon_r.data);
                check("rd_error", m_err, mon_r.err);
                check("latency", cyc - t0, mon_r.lat);
            end
        end
        if (!rst_s) begin
            if (chk_stab && (m_clk || prev_clk) && {m_i, m_ce, m_wr} != {prev_i, prev_ce, prev_wr})
                stab_viol++;
            if (!valid3 && data3 != ld3) hold_viol++;
            if (!valid5 && data5 != ld5) hold_viol++;
        end
        if (m_clk && prev_clk) gap_viol++;
        if (chk_stab && rise) begin
            if (have_rise && (cyc - last_rise) != (sel ? 5 : 3)) gap_viol++;
            have_rise = 1'b1;
            last_rise = cyc;
        end
        ld3 = data3;
        ld5 = data5;
        prev_clk = m_clk; prev_ce = m_ce; prev_wr = m_wr; prev_i = m_i;
    end

    task automatic start_read(input logic [5:0] a, input logic [15:0] hdr, input int pre,
                              input int mid, input logic [7:0] hi, input logic [7:0] lo,
                              input logic [15:0] ed, input logic ee, input int lat);
        logic [15:0] w[10];
        res_t r;
        w = '{16'hFFFF, 16'hAA99, 16'h2000, hdr, 16'h2000, 16'h2000,
              16'h30A1, 16'h000D, 16'h2000, 16'h2000};
        m_pre = pre; m_mid = mid; m_hi = hi; m_lo = lo;
        for (int k = 0; k < 10; k++) begin
            byte_q.push_back(w[k][15:8]);
            byte_q.push_back(w[k][7:0]);
        end
        r = '{ed, ee, lat};
        res_q.push_back(r);
        @(negedge clk);
        check("ready_before_req", m_ready, 1);
        reg_addr = a;
        req      = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        req      = 1'b0;
        reg_addr = 6'($urandom);
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int k;
        k = 0;
        while ((res_q.size() != 0 || !m_ready) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check({name, "_completed"}, (k < maxc), 1);
        check({name, "_bytes_left"}, byte_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vt[0] = '{6'h14, 16'h2A81,  0,  0, 8'h00, 8'h02, 16'h0002, 1'b0,  79};
        vt[1] = '{6'h13, 16'h2A61,  5,  0, 8'h12, 8'h34, 16'h1234, 1'b0,  94};
        vt[2] = '{6'h14, 16'h2A81, 40,  0, 8'h55, 8'h66, 16'h0000, 1'b1, 169};
        vt[3] = '{6'h08, 16'h2901, 31,  0, 8'hA5, 8'h5A, 16'hA55A, 1'b0, 172};
        vt[4] = '{6'h13, 16'h2A61, 32,  0, 8'h77, 8'h88, 16'h0000, 1'b1, 169};
        vt[5] = '{6'h3F, 16'h2FE1,  1,  0, 8'hFF, 8'h80, 16'hFF80, 1'b0,  82};
        vt[6] = '{6'h14, 16'h2A81,  2,  3, 8'hBE, 8'hEF, 16'hBEEF, 1'b0,  94};
        vt[7] = '{6'h13, 16'h2A61,  0, 40, 8'h9C, 8'hDE, 16'h0000, 1'b1, 172};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", ready3, 1);
        check("rst_rd_valid", valid3, 0);
        check("rst_rd_error", err3, 0);
        check("rst_rd_data", data3, 16'h0000);
        check("rst_icap_clk", clk3, 0);
        check("rst_icap_ce", ce3, 1);
        check("rst_icap_write", wr3, 1);
        check("rst_icap_i", i3, 8'h00);
        check("rst5_ready", ready5, 1);
        check("rst5_icap_ce", ce5, 1);

        chk_stab = 1'b1;
        for (int v = 0; v < 8; v++) begin
            start_read(vt[v].addr, vt[v].hdr, vt[v].pre, vt[v].mid, vt[v].hi, vt[v].lo,
                       vt[v].data, vt[v].err, vt[v].lat);
            wait_idle("table", 400);
        end
        chk_stab = 1'b0;

        // Repeated req during a transfer must not start or queue another read.
        start_read(6'h14, 16'h2A81, 0, 0, 8'h11, 8'h22, 16'h1122, 1'b0, 79);
        for (int p = 0; p < 10; p++) begin
            @(negedge clk); req = 1'b1; reg_addr = 6'h13;
            @(negedge clk); req = 1'b0;
            repeat (3) @(negedge clk);
        end
        wait_idle("req_pulse", 200);
        start_read(6'h13, 16'h2A61, 0, 0, 8'h33, 8'h44, 16'h3344, 1'b0, 79);
        wait_idle("after_pulse", 200);

        // req coincident with rst is dropped.
        @(negedge clk); rst = 1'b1; req = 1'b1; reg_addr = 6'h14;
        @(negedge clk); rst = 1'b0; req = 1'b0;
        @(negedge clk);
        check("req_with_rst_ready", m_ready, 1);
        check("req_with_rst_ce", m_ce, 1);

        // rst in the middle of READ aborts without DESYNC.
        start_read(6'h14, 16'h2A81, 20, 0, 8'hAB, 8'hCD, 16'hABCD, 1'b0, 139);
        k = 0;
        while (!(!m_ce && m_wr) && k < 200) begin @(negedge clk); k++; end
        check("reached_read", (k < 200), 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_icap_ce", m_ce, 1);
        check("abort_icap_write", m_wr, 1);
        check("abort_icap_clk", m_clk, 0);
        check("abort_ready", m_ready, 1);
        check("abort_rd_valid", m_valid, 0);
        byte_q.delete();
        res_q.delete();
        repeat (100) @(negedge clk);
        check("abort_stays_idle", m_ce, 1);
        start_read(6'h13, 16'h2A61, 0, 0, 8'h12, 8'h34, 16'h1234, 1'b0, 79);
        wait_idle("after_abort", 200);

        check("stab_viol_div3", stab_viol, 0);
        check("gap_viol_div3", gap_viol, 0);

        // CLK_DIV = 5 instance.
        sel = 1'b1;
        @(negedge clk);
        chk_stab = 1'b1;
        start_read(6'h14, 16'h2A81, 0, 0, 8'h00, 8'h02, 16'h0002, 1'b0, 131);
        wait_idle("div5", 300);
        start_read(6'h13, 16'h2A61, 3, 0, 8'h12, 8'h34, 16'h1234, 1'b0, 146);
        wait_idle("div5_busy", 300);
        chk_stab = 1'b0;
        check("stab_viol_div5", stab_viol, 0);
        check("gap_viol_div5", gap_viol, 0);
        check("hold_viol", hold_viol, 0);
        check("div3_idle_during_div5", ready3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
